button_counter4: RTL and testbench
==================================

# button_counter4

Upstream input stage for the 4-bit-to-display decoder. Turns two active-low board pushbuttons into a debounced 4-bit up/down count and presents it on B3..B0, which feed the decoder's B3..B0 inputs directly. An optional switch load sets the count to an arbitrary value, so every decoder input can be reached by hand on the board.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); minimum 2; benches use 4.
- clk  in  1  system clock (50 MHz on board).
- reset  in  1  synchronous, active-high; sampled on rising clk.
- key_up_n  in  1  raw pushbuttons, asynchronous, active-low (0 = pressed). key_up_n increments; key_down_n (same form) decrements.
- load  in  1  synchronous load strobe, active-high, already synchronous to clk.
- sw  in  4  load value, MSB first.
- B3, B2, B1, B0  out  1 each  registered count, B3 = MSB.
- wrap  out  1  registered one-cycle pulse when the count wraps (15→0 up or 0→15 down).

## Operation
- Per key: two-flop synchronizer → debouncer → press detector.
- Debouncer: holds an accepted level `stable` (reset = 1, released) and a counter of width clog2(DEBOUNCE_CYCLES).
  - When the synchronized level equals `stable`, clear the counter.
  - When it differs, increment. On the cycle the counter would reach DEBOUNCE_CYCLES, flip `stable` and clear the counter.
  - Any return to the `stable` level before that clears the counter, so bounces shorter than DEBOUNCE_CYCLES are discarded.
- Press event: one-cycle pulse when `stable` goes 1→0. Release (0→1) produces no event. Holding a key gives exactly one event: no auto-repeat.
- Count update, priority order each cycle:
  - reset: count = 0, wrap = 0.
  - load: count = sw, wrap = 0. Key events in that cycle are dropped.
  - up and down events in the same cycle: no change, wrap = 0.
  - up event only: count + 1 mod 16; wrap = 1 iff old count = 15.
  - down event only: count − 1 mod 16; wrap = 1 iff old count = 0.
  - otherwise: hold, wrap = 0.
- All arithmetic is 4-bit unsigned with natural wrap-around. No saturation.

## Timing
- Reset values: B3..B0 = 0000, wrap = 0, sync flops = 1, `stable` = 1, debounce counters = 0, event pulses = 0.
- Reset asserted mid-debounce discards the partial count. The key must then be seen pressed for a full DEBOUNCE_CYCLES after reset deasserts.
- Latency: key held low from edge k (first edge sampling 0) gives:
  - synchronized low visible after edge k+1;
  - `stable` = 0 after edge k+1+DEBOUNCE_CYCLES;
  - event pulse registered after edge k+2+DEBOUNCE_CYCLES;
  - B3..B0 and wrap updated after edge k+3+DEBOUNCE_CYCLES.
- Total key-to-output latency: DEBOUNCE_CYCLES + 3 cycles.
- Load latency: 1 cycle. sw sampled on the edge where load = 1; B3..B0 = sw after that edge.
- wrap is high for exactly the one cycle in which B3..B0 shows the wrapped value.
- Minimum spacing between accepted presses on one key: 2·DEBOUNCE_CYCLES cycles (press plus release).
- B3..B0 change only on clk edges and are glitch-free flop outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset held 3 cycles with keys released → B = 0000, wrap = 0 throughout; reset pulsed with count = 0101 → 0000 on the next edge.
- Clean up press held 10 cycles, then released → B goes 0000→0001 exactly 7 cycles after the first low sample and holds; no second increment on release.
- Up key bounces 0,1,0,1 (1 cycle each), then held low 6 cycles → exactly one increment, 7 cycles after the start of the final low run.
- load = 1 with sw = 1111, then one up press → B = 1111 after 1 cycle, then 0000 with wrap = 1 for one cycle. Then one down press → 1111 with wrap = 1.
- Up and down pressed on the same cycle, both held 10 cycles, starting from 0110 → B stays 0110, wrap stays 0.
- Load asserted on the same cycle as an up event, sw = 0011 → B = 0011, not 0100. Reset asserted 2 cycles into a press → no increment after reset releases unless the key stays low a further 4+ cycles.

Source files
------------

// File: rtl/button_counter4_if.sv
// rtl/button_counter4_if.sv - pushbutton/switch inputs and B3..B0/wrap outputs of button_counter4
interface button_counter4_if;
    logic       key_up_n;
    logic       key_down_n;
    logic       load;
    logic [3:0] sw;
    logic       B3;
    logic       B2;
    logic       B1;
    logic       B0;
    logic       wrap;

    modport master (
        output key_up_n, key_down_n, load, sw,
        input  B3, B2, B1, B0, wrap
    );

    modport slave (
        input  key_up_n, key_down_n, load, sw,
        output B3, B2, B1, B0, wrap
    );
endinterface

// File: rtl/button_counter4.sv
// rtl/button_counter4.sv - debounced up/down pushbutton counter with switch load, feeding a 4-bit decoder
module button_counter4 #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    button_counter4_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // bit 0 = up key, bit 1 = down key; all key levels are active-low
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [1:0]    ev;
    logic [CW-1:0] cnt [2];

    logic [3:0]    count;
    logic          wrap_q;
    logic [3:0]    next_count;
    logic          next_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            stable   <= 2'b11;
            stable_d <= 2'b11;
            ev       <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1    <= {bus.key_down_n, bus.key_up_n};
            sync2    <= sync1;
            stable_d <= stable;
            // a press is the accepted level falling; release is ignored
            ev       <= stable_d & ~stable;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        if (bus.load) begin
            next_count = bus.sw;
        end else if (ev == 2'b01) begin
            next_count = count + 4'd1;
            next_wrap  = (count == 4'd15);
        end else if (ev == 2'b10) begin
            next_count = count - 4'd1;
            next_wrap  = (count == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 4'd0;
            wrap_q <= 1'b0;
        end else begin
            count  <= next_count;
            wrap_q <= next_wrap;
        end
    end

    assign bus.B3   = count[3];
    assign bus.B2   = count[2];
    assign bus.B1   = count[1];
    assign bus.B0   = count[0];
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_button_counter4.sv
// tb/tb_button_counter4.sv - self-checking bench for button_counter4
module tb_button_counter4;
    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    button_counter4_if bus ();

    button_counter4 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         op;
        logic [3:0] sw;
        logic [3:0] exp_b;
        logic       exp_wrap;
    } vec_t;

    typedef struct {
        int         due;
        logic [3:0] b;
        logic       w;
        string      name;
    } exp_t;

    vec_t       vecs [11];
    exp_t       q [$];
    exp_t       e;
    logic [3:0] cur;

    function automatic logic [3:0] bval();
        return {bus.B3, bus.B2, bus.B1, bus.B0};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_at(input int due, input logic [3:0] b, input logic w, input string name);
        exp_t x;
        x.due = due; x.b = b; x.w = w; x.name = name;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_late: due %0d seen at %0d", e.name, e.due, cyc);
            end else begin
                check({e.name, "_b"}, bval(), e.b);
                check({e.name, "_wrap"}, {3'b000, bus.wrap}, {3'b000, e.w});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn, input logic [3:0] eb, input logic ew, input string name);
        int s;
        s = cyc;
        bus.key_up_n   = ~up;
        bus.key_down_n = ~dn;
        expect_at(s + LAT, cur, 1'b0, {name, "_before"});
        expect_at(s + LAT + 1, eb, ew, name);
        expect_at(s + LAT + 2, eb, 1'b0, {name, "_after"});
        repeat (10) tick();
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        repeat (14) tick();
        cur = eb;
    endtask

    task automatic load_op(input logic [3:0] v, input string name);
        int s;
        s = cyc;
        bus.load = 1'b1;
        bus.sw   = v;
        expect_at(s, cur, 1'b0, {name, "_before"});
        expect_at(s + 1, v, 1'b0, name);
        tick();
        bus.load = 1'b0;
        bus.sw   = 4'h0;
        tick();
        cur = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        // op: 0 load, 1 up, 2 down, 3 both keys together
        vecs[0]  = '{1, 4'h0, 4'h1, 1'b0};
        vecs[1]  = '{2, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{2, 4'h0, 4'hF, 1'b1};
        vecs[3]  = '{1, 4'h0, 4'h0, 1'b1};
        vecs[4]  = '{0, 4'h6, 4'h6, 1'b0};
        vecs[5]  = '{3, 4'h0, 4'h6, 1'b0};
        vecs[6]  = '{0, 4'hF, 4'hF, 1'b0};
        vecs[7]  = '{1, 4'h0, 4'h0, 1'b1};
        vecs[8]  = '{2, 4'h0, 4'hF, 1'b1};
        vecs[9]  = '{0, 4'hA, 4'hA, 1'b0};
        vecs[10] = '{2, 4'h0, 4'h9, 1'b0};

        reset          = 1'b1;
        bus.key_up_n   = 1'b1;
        bus.key_down_n = 1'b1;
        bus.load       = 1'b0;
        bus.sw         = 4'h0;
        cur            = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_b", bval(), 4'h0);
            check("reset_wrap", {3'b000, bus.wrap}, 4'h0);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 11; i++) begin
            case (vecs[i].op)
                0:       load_op(vecs[i].sw, $sformatf("vec%0d_load", i));
                1:       press(1'b1, 1'b0, vecs[i].exp_b, vecs[i].exp_wrap, $sformatf("vec%0d_up", i));
                2:       press(1'b0, 1'b1, vecs[i].exp_b, vecs[i].exp_wrap, $sformatf("vec%0d_down", i));
                default: press(1'b1, 1'b1, vecs[i].exp_b, vecs[i].exp_wrap, $sformatf("vec%0d_both", i));
            endcase
        end

        load_op(4'h5, "preload5");
        s = cyc;
        reset = 1'b1;
        expect_at(s, cur, 1'b0, "rst_pulse_before");
        expect_at(s + 1, 4'h0, 1'b0, "rst_pulse");
        tick();
        reset = 1'b0;
        tick();
        cur = 4'h0;

        // bouncing up key: only the final long low run counts
        s = cyc;
        bus.key_up_n = 1'b0; tick();
        bus.key_up_n = 1'b1; tick();
        bus.key_up_n = 1'b0; tick();
        bus.key_up_n = 1'b1; tick();
        bus.key_up_n = 1'b0;
        expect_at(s + 4 + LAT, cur, 1'b0, "bounce_before");
        expect_at(s + 5 + LAT, 4'h1, 1'b0, "bounce");
        expect_at(s + 6 + LAT, 4'h1, 1'b0, "bounce_after");
        repeat (6) tick();
        bus.key_up_n = 1'b1;
        repeat (14) tick();
        cur = 4'h1;

        // load collides with the up event; the load wins
        s = cyc;
        bus.key_up_n = 1'b0;
        repeat (LAT) tick();
        bus.load = 1'b1;
        bus.sw   = 4'h3;
        expect_at(s + LAT, cur, 1'b0, "load_vs_up_before");
        expect_at(s + LAT + 1, 4'h3, 1'b0, "load_vs_up");
        expect_at(s + LAT + 2, 4'h3, 1'b0, "load_vs_up_after");
        tick();
        bus.load = 1'b0;
        bus.sw   = 4'h0;
        repeat (4) tick();
        bus.key_up_n = 1'b1;
        repeat (14) tick();
        cur = 4'h3;

        // reset two cycles into a short press: partial debounce is discarded
        s = cyc;
        bus.key_up_n = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        expect_at(s + 3, 4'h0, 1'b0, "rst_mid_short");
        expect_at(s + 20, 4'h0, 1'b0, "rst_mid_short_hold");
        tick();
        reset = 1'b0;
        repeat (2) tick();
        bus.key_up_n = 1'b1;
        repeat (20) tick();
        cur = 4'h0;

        // reset mid-press, key kept low: full debounce restarts after reset
        s = cyc;
        bus.key_up_n = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        expect_at(s + 3, 4'h0, 1'b0, "rst_mid_long_reset");
        expect_at(s + 3 + LAT, 4'h0, 1'b0, "rst_mid_long_before");
        expect_at(s + 4 + LAT, 4'h1, 1'b0, "rst_mid_long");
        expect_at(s + 5 + LAT, 4'h1, 1'b0, "rst_mid_long_after");
        tick();
        reset = 1'b0;
        repeat (10) tick();
        bus.key_up_n = 1'b1;
        repeat (14) tick();

        repeat (5) tick();
        while (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s_unchecked: due %0d never reached", e.name, e.due);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
